// File: rtl/stage_fe.sv
// stage_fe: instruction fetch front end.
// Issues one word-aligned fetch at a time, holds at most one returned
// instruction while decode stalls, and handles redirects, including
// responses to requests that are already in flight.
module stage_fe #(
    parameter int unsigned               INST_ADDR_W = 32,
    parameter int unsigned               INST_W      = 32,
    parameter logic [INST_ADDR_W-1:0]    RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [INST_ADDR_W-1:0] redirect_pc,
    output logic                   imem_req,
    output logic [INST_ADDR_W-1:0] imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [INST_W-1:0]      imem_rdata,
    output logic [INST_W-1:0]      inst,
    output logic [INST_ADDR_W-1:0] pc,
    output logic                   flush
);

    localparam logic [INST_ADDR_W-1:0] PC_INC = INST_ADDR_W'(4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t                 state_q, state_d;
    logic                   req_q, req_d;
    logic                   discard_q, discard_d;
    logic [INST_ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [INST_ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic [INST_ADDR_W-1:0] wait_pc_q, wait_pc_d;
    logic [INST_ADDR_W-1:0] buf_pc_q, buf_pc_d;
    logic [INST_W-1:0]      buf_inst_q, buf_inst_d;
    logic [INST_ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0]      inst_q, inst_d;
    logic                   flush_q, flush_d;

    logic                   advance;
    logic [INST_ADDR_W-1:0] redir_al;

    assign advance  = en && !stall;
    assign redir_al = {redirect_pc[INST_ADDR_W-1:2], 2'b00};

    // Next-state, fetch address and output register computation.
    always_comb begin
        state_d    = state_q;
        discard_d  = discard_q;
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        wait_pc_d  = wait_pc_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        flush_d    = flush_q;

        if (redirect_valid) begin
            if (en) begin
                flush_d = 1'b1;
            end
            unique case (state_q)
                S_REQ: begin
                    // A presented request keeps its address until granted;
                    // the target waits in pend_pc and the request is discarded.
                    discard_d = 1'b1;
                    if (imem_gnt) begin
                        wait_pc_d  = fetch_pc_q;
                        fetch_pc_d = redir_al;
                        state_d    = S_WAIT;
                    end else begin
                        pend_pc_d = redir_al;
                    end
                end
                S_WAIT: begin
                    fetch_pc_d = redir_al;
                    if (imem_rvalid) begin
                        discard_d = 1'b0;
                        state_d   = en ? S_REQ : S_IDLE;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                default: begin
                    // IDLE or HOLD: nothing in flight, buffered word is dropped.
                    fetch_pc_d = redir_al;
                    discard_d  = 1'b0;
                    state_d    = en ? S_REQ : S_IDLE;
                end
            endcase
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (en) begin
                        state_d = S_REQ;
                    end
                    if (advance) begin
                        flush_d = 1'b1;
                    end
                end
                S_REQ: begin
                    if (advance) begin
                        flush_d = 1'b1;
                    end
                    if (imem_gnt) begin
                        wait_pc_d  = fetch_pc_q;
                        fetch_pc_d = discard_q ? pend_pc_q : fetch_pc_q + PC_INC;
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = en ? S_REQ : S_IDLE;
                            if (advance) begin
                                flush_d = 1'b1;
                            end
                        end else if (advance) begin
                            inst_d  = imem_rdata;
                            pc_d    = wait_pc_q;
                            flush_d = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            buf_inst_d = imem_rdata;
                            buf_pc_d   = wait_pc_q;
                            state_d    = S_HOLD;
                        end
                    end else if (advance) begin
                        flush_d = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (advance) begin
                        inst_d  = buf_inst_q;
                        pc_d    = buf_pc_q;
                        flush_d = 1'b0;
                        state_d = S_REQ;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        req_d = (state_d == S_REQ);
    end

    // State and output registers, asynchronously reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            discard_q  <= 1'b0;
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= RESET_PC;
            wait_pc_q  <= RESET_PC;
            buf_pc_q   <= RESET_PC;
            buf_inst_q <= '0;
            pc_q       <= RESET_PC;
            inst_q     <= '0;
            flush_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            discard_q  <= discard_d;
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            wait_pc_q  <= wait_pc_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            flush_q    <= flush_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = fetch_pc_q;
    assign inst      = inst_q;
    assign pc        = pc_q;
    assign flush     = flush_q;

endmodule

// File: tb/tb_stage_fe.sv
// Directed vector bench for stage_fe: each row drives one cycle of inputs
// and gives the outputs expected just after the following rising edge.
module tb_stage_fe;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        flush;

    int unsigned n_total;
    int unsigned n_pass;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_flush;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vecs[$];

    stage_fe #(
        .INST_ADDR_W (32),
        .INST_W      (32),
        .RESET_PC    (32'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst           (inst),
        .pc             (pc),
        .flush          (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic add(input logic r, input logic e, input logic s, input logic rv,
                       input logic [31:0] rpc, input logic g, input logic vl,
                       input logic [31:0] rd, input logic xq, input logic [31:0] xa,
                       input logic xf, input logic [31:0] xp, input logic [31:0] xi);
        vec_t v;
        v.rst_n = r;  v.en = e;  v.stall = s;  v.rv = rv;  v.rpc = rpc;
        v.gnt = g;    v.rvalid = vl;  v.rdata = rd;
        v.e_req = xq; v.e_addr = xa;  v.e_flush = xf;  v.e_pc = xp;  v.e_inst = xi;
        vecs.push_back(v);
    endtask

    task automatic check_outs(input string tag, input logic xq, input logic [31:0] xa,
                              input logic xf, input logic [31:0] xp, input logic [31:0] xi);
        check({tag, ".req"},   32'(imem_req), 32'(xq));
        check({tag, ".addr"},  imem_addr, xa);
        check({tag, ".flush"}, 32'(flush), 32'(xf));
        check({tag, ".pc"},    pc, xp);
        check({tag, ".inst"},  inst, xi);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;

        //   rst en st rv rpc           gnt vl rdata          req addr          fl pc            inst
        // Straight-line fetch 0,4,8
        add(1, 1, 0, 0, 32'h0,   0, 0, 32'h0,         1, 32'h0,   1, 32'h0,   32'h0);
        add(1, 1, 0, 0, 32'h0,   1, 0, 32'h0,         0, 32'h4,   1, 32'h0,   32'h0);
        add(1, 1, 0, 0, 32'h0,   0, 1, 32'h10000000,  1, 32'h4,   0, 32'h0,   32'h10000000);
        add(1, 1, 0, 0, 32'h0,   1, 0, 32'h0,         0, 32'h8,   1, 32'h0,   32'h10000000);
        add(1, 1, 0, 0, 32'h0,   0, 1, 32'h10000004,  1, 32'h8,   0, 32'h4,   32'h10000004);
        add(1, 1, 0, 0, 32'h0,   1, 0, 32'h0,         0, 32'hC,   1, 32'h4,   32'h10000004);
        // Response for 0x8 arrives under a 3-cycle stall
        add(1, 1, 1, 0, 32'h0,   0, 1, 32'h10000008,  0, 32'hC,   1, 32'h4,   32'h10000004);
        add(1, 1, 1, 0, 32'h0,   0, 0, 32'h0,         0, 32'hC,   1, 32'h4,   32'h10000004);
        add(1, 1, 1, 0, 32'h0,   0, 0, 32'h0,         0, 32'hC,   1, 32'h4,   32'h10000004);
        add(1, 1, 0, 0, 32'h0,   0, 0, 32'h0,         1, 32'hC,   0, 32'h8,   32'h10000008);
        add(1, 1, 0, 0, 32'h0,   1, 0, 32'h0,         0, 32'h10,  1, 32'h8,   32'h10000008);
        add(1, 1, 0, 0, 32'h0,   0, 1, 32'h1000000C,  1, 32'h10,  0, 32'hC,   32'h1000000C);
        add(1, 1, 0, 0, 32'h0,   1, 0, 32'h0,         0, 32'h14,  1, 32'hC,   32'h1000000C);
        // Redirect to 0x100 while 0x10 is in flight
        add(1, 1, 0, 1, 32'h100, 0, 0, 32'h0,         0, 32'h100, 1, 32'hC,   32'h1000000C);
        add(1, 1, 0, 0, 32'h0,   0, 1, 32'h10000010,  1, 32'h100, 1, 32'hC,   32'h1000000C);
        add(1, 1, 0, 0, 32'h0,   1, 0, 32'h0,         0, 32'h104, 1, 32'hC,   32'h1000000C);
        add(1, 1, 0, 0, 32'h0,   0, 1, 32'h10000100,  1, 32'h104, 0, 32'h100, 32'h10000100);
        // Grant withheld 4 cycles, redirect to 0x200 inside the window
        add(1, 1, 0, 0, 32'h0,   0, 0, 32'h0,         1, 32'h104, 1, 32'h100, 32'h10000100);
        add(1, 1, 0, 0, 32'h0,   0, 0, 32'h0,         1, 32'h104, 1, 32'h100, 32'h10000100);
        add(1, 1, 0, 1, 32'h200, 0, 0, 32'h0,         1, 32'h104, 1, 32'h100, 32'h10000100);
        add(1, 1, 0, 0, 32'h0,   0, 0, 32'h0,         1, 32'h104, 1, 32'h100, 32'h10000100);
        add(1, 1, 0, 0, 32'h0,   1, 0, 32'h0,         0, 32'h200, 1, 32'h100, 32'h10000100);
        add(1, 1, 0, 0, 32'h0,   0, 1, 32'h10000104,  1, 32'h200, 1, 32'h100, 32'h10000100);
        add(1, 1, 0, 0, 32'h0,   1, 0, 32'h0,         0, 32'h204, 1, 32'h100, 32'h10000100);
        // Buffered under stall, then unaligned redirect 0x203
        add(1, 1, 1, 0, 32'h0,   0, 1, 32'h10000200,  0, 32'h204, 1, 32'h100, 32'h10000100);
        add(1, 1, 1, 1, 32'h203, 0, 0, 32'h0,         1, 32'h200, 1, 32'h100, 32'h10000100);
        add(1, 1, 0, 0, 32'h0,   1, 0, 32'h0,         0, 32'h204, 1, 32'h100, 32'h10000100);
        add(1, 1, 0, 0, 32'h0,   0, 1, 32'h10000200,  1, 32'h204, 0, 32'h200, 32'h10000200);
        // Redirect coincident with rvalid, then with gnt
        add(1, 1, 0, 0, 32'h0,   1, 0, 32'h0,         0, 32'h208, 1, 32'h200, 32'h10000200);
        add(1, 1, 0, 1, 32'h300, 0, 1, 32'h10000204,  1, 32'h300, 1, 32'h200, 32'h10000200);
        add(1, 1, 0, 1, 32'h400, 1, 0, 32'h0,         0, 32'h400, 1, 32'h200, 32'h10000200);
        add(1, 1, 0, 0, 32'h0,   0, 1, 32'h10000300,  1, 32'h400, 1, 32'h200, 32'h10000200);
        // Enable low: request completes, response buffered, outputs frozen
        add(1, 0, 0, 0, 32'h0,   0, 0, 32'h0,         1, 32'h400, 1, 32'h200, 32'h10000200);
        add(1, 0, 0, 0, 32'h0,   1, 0, 32'h0,         0, 32'h404, 1, 32'h200, 32'h10000200);
        add(1, 0, 0, 0, 32'h0,   0, 1, 32'h10000400,  0, 32'h404, 1, 32'h200, 32'h10000200);
        add(1, 1, 0, 0, 32'h0,   0, 0, 32'h0,         1, 32'h404, 0, 32'h400, 32'h10000400);
        add(1, 1, 0, 0, 32'h0,   1, 0, 32'h0,         0, 32'h408, 1, 32'h400, 32'h10000400);
        // Reset pulse during WAIT, stale responses afterwards, restart at 0
        add(0, 1, 0, 0, 32'h0,   0, 0, 32'h0,         0, 32'h0,   1, 32'h0,   32'h0);
        add(1, 1, 0, 0, 32'h0,   0, 1, 32'hDEADBEEF,  1, 32'h0,   1, 32'h0,   32'h0);
        add(1, 1, 0, 0, 32'h0,   0, 1, 32'hCAFEF00D,  1, 32'h0,   1, 32'h0,   32'h0);
        add(1, 1, 0, 0, 32'h0,   1, 0, 32'h0,         0, 32'h4,   1, 32'h0,   32'h0);
        add(1, 1, 0, 0, 32'h0,   0, 1, 32'h10000000,  1, 32'h4,   0, 32'h0,   32'h10000000);

        // Initial reset
        rst_n          = 1'b0;
        en             = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 32'h0, 1'b1, 32'h0, 32'h0);

        foreach (vecs[i]) begin
            rst_n          = vecs[i].rst_n;
            en             = vecs[i].en;
            stall          = vecs[i].stall;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            imem_gnt       = vecs[i].gnt;
            imem_rvalid    = vecs[i].rvalid;
            imem_rdata     = vecs[i].rdata;
            if (!vecs[i].rst_n) begin
                // Reset must act before any clock edge
                #2;
                check($sformatf("v%0d.async_req", i),   32'(imem_req), 32'h0);
                check($sformatf("v%0d.async_flush", i), 32'(flush), 32'h1);
                check($sformatf("v%0d.async_pc", i),    pc, 32'h0);
            end
            @(posedge clk);
            #1;
            check_outs($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr,
                       vecs[i].e_flush, vecs[i].e_pc, vecs[i].e_inst);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
